// File: rtl/rr_packet_mux.sv
// N-to-1 packet multiplexer: round-robin or fixed-priority arbitration, grant held
// until the tail flit is accepted, and one registered valid/ready output stage.
module rr_packet_mux #(
    parameter int  NPORT    = 5,
    parameter int  WIDTH    = 8,
    parameter int  PRIORITY = 0,
    localparam int PW       = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       in_valid,
    input  logic [NPORT-1:0]       in_last,
    input  logic [NPORT*WIDTH-1:0] in_data,
    output logic [NPORT-1:0]       in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [PW-1:0]          out_port,
    output logic                   busy
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [PW-1:0]    r_lock, w_lock_nxt;
    logic [NPORT-1:0] w_grant;
    logic [PW-1:0]    w_gidx;
    logic             w_load_en;
    logic             w_xfer;
    logic             w_sel_last;
    logic [WIDTH-1:0] w_sel_data;

    logic             r_out_valid_p1;
    logic             r_out_last_p1;
    logic [WIDTH-1:0] r_out_data_p1;
    logic [PW-1:0]    r_out_port_p1;

    // First requester strictly after ptr, wrapping around.
    function automatic logic [PW-1:0] rr_pick(input logic [NPORT-1:0] req,
                                              input logic [PW-1:0]    ptr);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = (int'(ptr) + k) % NPORT;
            if (!found && req[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] fixed_pick(input logic [NPORT-1:0] req);
        logic [PW-1:0] pick;
        pick = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req[i]) pick = PW'(i);
        end
        return pick;
    endfunction

    assign w_load_en = !r_out_valid_p1 || out_ready;

    always_comb begin
        w_gidx  = '0;
        w_grant = '0;
        if (r_state == S_LOCKED) begin
            w_gidx          = r_lock;
            w_grant[r_lock] = 1'b1;
        end else if (|in_valid) begin
            w_gidx          = (PRIORITY != 0) ? fixed_pick(in_valid) : rr_pick(in_valid, r_ptr);
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign in_ready   = (w_load_en && !rst) ? (w_grant & in_valid) : '0;
    assign w_xfer     = |in_ready;
    assign w_sel_data = in_data[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_sel_last = in_last[w_gidx];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (w_sel_last) begin
                        w_ptr_nxt = w_gidx;
                    end else begin
                        w_state_nxt = S_LOCKED;
                        w_lock_nxt  = w_gidx;
                    end
                end
            end
            S_LOCKED: begin
                if (w_xfer && w_sel_last) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = r_lock;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= PW'(NPORT - 1);
            r_lock  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    // p0 -> p1: output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_p1 <= 1'b0;
            r_out_last_p1  <= 1'b0;
            r_out_data_p1  <= '0;
            r_out_port_p1  <= '0;
        end else if (w_load_en) begin
            r_out_valid_p1 <= w_xfer;
            if (w_xfer) begin
                r_out_data_p1 <= w_sel_data;
                r_out_last_p1 <= w_sel_last;
                r_out_port_p1 <= w_gidx;
            end
        end
    end

    assign out_valid = r_out_valid_p1;
    assign out_data  = r_out_data_p1;
    assign out_last  = r_out_last_p1;
    assign out_port  = r_out_port_p1;
    assign busy      = (r_state == S_LOCKED);

endmodule

// File: tb/tb_rr_packet_mux.sv
// Bench for rr_packet_mux: a round-robin instance driven from per-port flit queues with
// a scoreboard of expected output flits, plus a fixed-priority instance driven directly.
module tb_rr_packet_mux;

    localparam int NPORT = 5;
    localparam int WIDTH = 8;
    localparam int PW    = 3;

    typedef struct packed {
        logic [PW-1:0]    port;
        logic             last;
        logic [WIDTH-1:0] data;
    } flit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   out_ready;
    logic                   force_all;
    logic [NPORT-1:0]       src_has, en;
    logic [NPORT-1:0]       in_valid, in_last, in_ready;
    logic [NPORT*WIDTH-1:0] in_data;
    logic                   out_valid, out_last, busy;
    logic [WIDTH-1:0]       out_data;
    logic [PW-1:0]          out_port;

    logic [NPORT-1:0]       fp_in_valid, fp_in_last, fp_in_ready;
    logic [NPORT*WIDTH-1:0] fp_in_data;
    logic                   fp_out_valid, fp_out_last, fp_busy;
    logic [WIDTH-1:0]       fp_out_data;
    logic [PW-1:0]          fp_out_port;

    assign in_valid = force_all ? '1 : (src_has & en);

    rr_packet_mux #(.NPORT(NPORT), .WIDTH(WIDTH), .PRIORITY(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_port(out_port), .busy(busy)
    );

    rr_packet_mux #(.NPORT(NPORT), .WIDTH(WIDTH), .PRIORITY(1)) dut_fp (
        .clk(clk), .rst(rst),
        .in_valid(fp_in_valid), .in_last(fp_in_last), .in_data(fp_in_data), .in_ready(fp_in_ready),
        .out_valid(fp_out_valid), .out_ready(1'b1), .out_data(fp_out_data),
        .out_last(fp_out_last), .out_port(fp_out_port), .busy(fp_busy)
    );

    flit_t            exp_q[$];
    logic [WIDTH:0]   src_q[NPORT][$];
    int               n_chk  = 0;
    int               n_fail = 0;
    logic             mon_en;
    logic [NPORT-1:0] s_in_ready, s_fp_in_ready;
    logic             s_out_valid, s_busy;
    logic [WIDTH-1:0] s_out_data;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic src_push(input int p, input logic l, input logic [WIDTH-1:0] d);
        src_q[p].push_back({l, d});
    endtask

    task automatic exp_push(input int p, input logic l, input logic [WIDTH-1:0] d);
        flit_t e;
        e.port = PW'(p);
        e.last = l;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Idle ports present X so any leak of ungranted data shows up at the output.
    task automatic present();
        for (int i = 0; i < NPORT; i++) begin
            if (src_q[i].size() > 0) begin
                src_has[i] = 1'b1;
                {in_last[i], in_data[i*WIDTH +: WIDTH]} = src_q[i][0];
            end else begin
                src_has[i]                = 1'b0;
                in_last[i]                = 1'bx;
                in_data[i*WIDTH +: WIDTH] = 'x;
            end
        end
    endtask

    task automatic step();
        flit_t            e;
        logic [NPORT-1:0] acc;
        @(negedge clk);
        acc           = in_ready;
        s_in_ready    = in_ready;
        s_fp_in_ready = fp_in_ready;
        s_out_valid   = out_valid;
        s_out_data    = out_data;
        s_busy        = busy;
        if (mon_en) begin
            chk("in_ready_onehot", 32'($countones(in_ready) <= 1), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_flit", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_port", 32'(out_port), 32'(e.port));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NPORT; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        present();
    endtask

    task automatic drain(input int max_cyc, output int n);
        n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst         = 1'b1;
        force_all   = 1'b1;
        out_ready   = 1'b1;
        en          = '1;
        mon_en      = 1'b0;
        src_has     = '0;
        in_last     = '0;
        in_data     = '0;
        fp_in_valid = '1;
        fp_in_last  = '1;
        fp_in_data  = '0;

        // Reset with every port requesting
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_in_ready", 32'(s_in_ready), 0);
            chk("rst_fp_in_ready", 32'(s_fp_in_ready), 0);
        end
        rst         = 1'b0;
        force_all   = 1'b0;
        fp_in_valid = '0;
        present();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_port", 32'(out_port), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fp_out_valid", 32'(fp_out_valid), 0);
        mon_en = 1'b1;

        // Fixed priority: ports 1 and 3 requesting, port 1 wins until it drops
        fp_in_data  = {8'h00, 8'h33, 8'h00, 8'h11, 8'h00};
        fp_in_valid = 5'b01010;
        step();
        chk("fp_ready_p1", 32'(s_fp_in_ready), 32'b00010);
        chk("fp_valid_p1", 32'(fp_out_valid), 1);
        chk("fp_data_p1", 32'(fp_out_data), 32'h11);
        chk("fp_port_p1", 32'(fp_out_port), 1);
        step();
        chk("fp_ready_hold", 32'(s_fp_in_ready), 32'b00010);
        fp_in_valid = 5'b01000;
        step();
        chk("fp_ready_p3", 32'(s_fp_in_ready), 32'b01000);
        chk("fp_data_p3", 32'(fp_out_data), 32'h33);
        chk("fp_port_p3", 32'(fp_out_port), 3);
        fp_in_valid = '0;
        step();
        chk("fp_idle_valid", 32'(fp_out_valid), 0);

        // Round-robin over all ports, one flit per cycle
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NPORT; i++) begin
                src_push(i, 1'b1, 8'(8'hA0 + i));
                exp_push(i, 1'b1, 8'(8'hA0 + i));
            end
        present();
        drain(30, n);
        chk("rr_throughput", 32'(n), 11);
        chk("rr_busy", 32'(busy), 0);

        // Packet lock: port 1 single flit moves the pointer so port 2 wins next
        src_push(1, 1'b1, 8'h01);
        exp_push(1, 1'b1, 8'h01);
        present();
        drain(10, n);
        src_push(2, 1'b0, 8'hC0);
        src_push(2, 1'b0, 8'hC1);
        src_push(2, 1'b1, 8'hC2);
        src_push(0, 1'b1, 8'h05);
        exp_push(2, 1'b0, 8'hC0);
        exp_push(2, 1'b0, 8'hC1);
        exp_push(2, 1'b1, 8'hC2);
        exp_push(0, 1'b1, 8'h05);
        present();
        step();
        chk("lock_ready_0", 32'(s_in_ready), 32'b00100);
        chk("lock_busy_0", 32'(busy), 1);
        step();
        chk("lock_ready_1", 32'(s_in_ready), 32'b00100);
        chk("lock_busy_1", 32'(busy), 1);
        step();
        chk("lock_ready_2", 32'(s_in_ready), 32'b00100);
        step();
        chk("unlock_ready", 32'(s_in_ready), 32'b00001);
        chk("unlock_busy", 32'(s_busy), 0);
        drain(10, n);

        // Backpressure: stall after the first output flit
        src_push(3, 1'b0, 8'h30);
        src_push(3, 1'b0, 8'h31);
        src_push(3, 1'b1, 8'h32);
        src_push(1, 1'b1, 8'h1F);
        exp_push(1, 1'b1, 8'h1F);
        exp_push(3, 1'b0, 8'h30);
        exp_push(3, 1'b0, 8'h31);
        exp_push(3, 1'b1, 8'h32);
        present();
        step();
        chk("bp_first_ready", 32'(s_in_ready), 32'b00010);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_in_ready", 32'(s_in_ready), 0);
            chk("bp_out_valid", 32'(s_out_valid), 1);
            chk("bp_out_data", 32'(s_out_data), 32'h1F);
        end
        out_ready = 1'b1;
        drain(20, n);

        // Source stall while locked, then reset mid-packet
        src_push(4, 1'b0, 8'h40);
        src_push(4, 1'b0, 8'h41);
        src_push(4, 1'b1, 8'h42);
        exp_push(4, 1'b0, 8'h40);
        exp_push(4, 1'b0, 8'h41);
        present();
        step();
        chk("p4_win_ready", 32'(s_in_ready), 32'b10000);
        step();
        chk("p4_busy", 32'(busy), 1);
        en[4] = 1'b0;
        src_push(0, 1'b1, 8'h0A);
        present();
        step();
        chk("stall_ready_0", 32'(s_in_ready), 0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("stall_ready", 32'(s_in_ready), 0);
            chk("stall_out_valid", 32'(s_out_valid), 0);
            chk("stall_busy", 32'(s_busy), 1);
        end
        rst = 1'b1;
        step();
        chk("midrst_ready", 32'(s_in_ready), 0);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        en[4] = 1'b1;
        exp_push(0, 1'b1, 8'h0A);
        exp_push(4, 1'b1, 8'h42);
        present();
        step();
        chk("post_rst_ready", 32'(s_in_ready), 32'b00001);
        drain(10, n);

        chk("exp_q_empty", 32'(exp_q.size()), 0);
        for (int i = 0; i < NPORT; i++) chk("src_q_empty", 32'(src_q[i].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_packet_mux.md
Name: rr_packet_mux

Overview:
- Parametrised N-to-1 router output multiplexer. Each input port carries a flit stream framed by a tail flag.
- Arbitrates among requesting input ports, either round-robin or fixed priority with port 0 highest.
- Locks the grant to one port until that port's tail flit is accepted.
- Drives one registered output flit channel with valid/ready backpressure. Sits between the input buffers and an output link of the router.

Parameters:
- NPORT, 5, number of input ports (>=2).
- WIDTH, 8, flit data width in bits.
- PRIORITY, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- PW, $clog2(NPORT) (min 1), width of port-index fields; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  NPORT  bit i: port i presents a flit.
- in_last  in  NPORT  bit i: port i's flit is the packet tail.
- in_data  in  NPORT*WIDTH  port i flit at [WIDTH*(i+1)-1:WIDTH*i].
- in_ready  out  NPORT  bit i: port i flit is accepted this cycle; at most one bit high.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts output flit.
- out_data  out  WIDTH  registered output flit.
- out_last  out  1  registered tail flag.
- out_port  out  PW  binary index of the source port of the current output flit.
- busy  out  1  high while in LOCKED state.

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid, out_data, out_last, out_port and busy go to 0.
  - State goes to IDLE; round-robin pointer goes to NPORT-1, so port 0 wins first.
  - in_ready is forced to all-0 combinationally while rst=1.
  - Reset mid-packet drops the lock; any partial packet is abandoned, not completed.
- Output register load: load_en = !out_valid || out_ready.
- Grant and handshake:
  - in_ready[i] = grant[i] && in_valid[i] && load_en && !rst.
  - A transfer occurs on port g when in_ready[g]=1.
  - On transfer, the next edge loads out_data, out_last and out_port=g, and sets out_valid=1.
  - If load_en=1 with no transfer, out_valid goes to 0.
  - If load_en=0, the output register holds.
  - Latency is 1 cycle input-to-output; throughput is 1 flit/cycle with out_ready held high.
- State IDLE:
  - grant is combinational, one-hot, over in_valid.
  - PRIORITY=1: lowest-index valid port wins.
  - PRIORITY=0: first valid port scanning circularly from pointer+1.
  - No valid port: grant=0.
  - On transfer with in_last=1 (single-flit packet): stay IDLE; pointer := g.
  - On transfer with in_last=0: go to LOCKED with lock := g.
  - No transfer (backpressure): nothing changes; the winner is re-evaluated next cycle, since no lock exists before the first transfer.
- State LOCKED:
  - grant is one-hot at lock, regardless of other requests.
  - The locked port deasserting in_valid mid-packet stalls the output; lock is held indefinitely.
  - On transfer with in_last=1: go to IDLE; pointer := lock.
  - busy = 1.
- Other rules:
  - The pointer updates only at packet end, in both modes; in fixed mode it is unused.
  - in_data of ungranted ports is ignored.
  - X on ungranted ports must not propagate to outputs.
  - No flit is dropped or duplicated under any out_ready pattern.
  - Upstream guarantees in_valid/data/last stay stable until in_ready.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles with in_valid=5'b11111 and out_ready=1.
   - Required: in_ready=0 both cycles; after the edge out_valid=0, out_data=0, out_port=0, busy=0.
2. Fixed priority (PRIORITY=1, NPORT=5, WIDTH=8):
   - Stimulus: ports 1 and 3 hold single-flit 0x11/0x33 (last=1), out_ready=1.
   - Required: cycle n+1 out_data=0x11, out_port=1. Port 3 is granted only once port 1 drops valid; then out_data=0x33, out_port=3.
3. Round-robin:
   - Stimulus: all 5 ports continuously valid with single flits, data=0xA0+i, out_ready=1.
   - Required: out_port sequence 0,1,2,3,4,0,1, one flit per cycle.
4. Packet lock:
   - Stimulus: port 2 sends 3 flits 0xC0,0xC1,0xC2 (last on 0xC2) starting the cycle it wins; port 0 is valid throughout; out_ready=1.
   - Required: output carries 0xC0,0xC1,0xC2 consecutively with out_port=2, busy=1 from after the first transfer; then port 0's flit, with the pointer scan from 3 reaching 0.
5. Backpressure:
   - Stimulus: after the first output flit, hold out_ready=0 for 4 cycles.
   - Required: out_valid=1 with out_data held; in_ready=0 every cycle; on release the remaining flits follow in order, with no loss or duplicate.
6. Reset mid-packet and source stall:
   - Stimulus: port 4 locked. Deassert its in_valid for 3 cycles mid-packet, then assert rst for 1 cycle.
   - Required:
     - During the stall: out_valid falls to 0 and no other port is granted.
     - After reset: busy=0; next arbitration (RR) with ports 0 and 4 valid grants port 0.
